alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Command-side front end for the combinational 32-bit ALU: accepts operation commands over a valid/ready handshake and drives the ALU operand/opcode/class ports.
- Captures each ALU result, computes its own flags and set-less-than result (the ALU does not produce one), and returns tagged results through a 2-entry output buffer with valid/ready.
- Sits between the instruction/issue logic and the ALU instance; the ALU itself is instantiated outside this block.

Parameters:
N, 32, operand/result width; must be a power of two, at least 4.
TAG_W, 4, width of the command tag carried through to the result.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid && in_ready
in_a  input  N  operand a
in_b  input  N  operand b
in_opcode  input  2  ALU opcode (shift / add-sub / logic sub-op)
in_fn_class  input  2  00 shift, 01 set-less, 10 arithmetic, 11 logic
in_tag  input  TAG_W  command tag
alu_a  output  N  to ALU a
alu_b  output  N  to ALU b
alu_opcode  output  2  to ALU opcode
alu_fn_class  output  2  to ALU fnClass
alu_out  input  N  from ALU out
alu_c_out  input  1  from ALU c_out
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid && res_ready
res_data  output  N  result
res_zero  output  1  res_data == 0
res_ovf  output  1  signed overflow (arithmetic class only)
res_carry  output  1  adder carry (arithmetic class only)
res_tag  output  TAG_W  tag of the command
stat_ops  output  32  completed-op count (optional feature)
stat_ovf  output  32  overflowed-op count (optional feature)

Behaviour:
- FSM states: IDLE, ISSUE. Reset to IDLE.
- Reset (async, rst_n low): output buffer emptied; all operand/command registers cleared; res_valid=0; res_data, res_zero, res_ovf, res_carry and res_tag all 0; alu_* outputs 0; stat_* 0.
- in_ready = (state == IDLE) && (buffer count < 2).
- Accept in cycle T: register a, b, opcode, class and tag; go to ISSUE.
- During ISSUE (cycle T+1), drive the ALU from the registered command:
  - class 00/10/11: drive the registered opcode and class unchanged.
  - class 01: drive alu_fn_class=10 and alu_opcode=11 (subtract).
- End of T+1: push one entry into the buffer and return to IDLE. res_valid is high from T+2 when the buffer was empty. Throughput is one command per 2 cycles.
- Entry contents:
  - class 00/11: data = alu_out, ovf = 0, carry = 0.
  - class 10: data = alu_out; carry = alu_c_out.
    - opcode 11 is subtract: b_eff = ~b+1. Opcodes 00/01/10 are add: b_eff = b.
    - ovf = (a[N-1] == b_eff[N-1]) && (alu_out[N-1] != a[N-1]).
  - class 01: v = (a[N-1] != b[N-1]) && (alu_out[N-1] != a[N-1]); data = {N-1 zeros, alu_out[N-1] ^ v}; ovf = 0; carry = 0.
  - zero = ~|data; tag = registered tag.
- Buffer behaviour:
  - 2-entry FIFO with in-order output; res_* show the head entry and hold stable while res_valid && !res_ready.
  - A push and pop in the same cycle leave the count unchanged.
  - in_ready guarantees space at push time, so a push is never dropped.
- alu_* outputs hold their last driven value in IDLE; the ALU output is don't-care outside ISSUE.

Optional Feature:
- ALU_SEQ_STATS_EN defined:
  - stat_ops increments by 1 on every buffer push.
  - stat_ovf increments on every push whose ovf = 1.
  - Both are 32-bit counters that wrap from 0xFFFFFFFF to 0 and reset to 0.
- Not defined: stat_ops and stat_ovf are tied to 0 and no counter registers exist.

Test Plan:
- Reset mid-ISSUE: assert rst_n low during ISSUE -> res_valid=0 and in_ready=0 immediately; after release in_ready=1 and no stale result ever appears.
- Add, N=32: a=0x7FFFFFFF, b=1, class 10, opcode 00, tag 3 -> res_valid at T+2, data 0x80000000, ovf=1, carry=0, zero=0, tag 3.
- Subtract: a=5, b=5, class 10, opcode 11 -> ALU driven with opcode 11; data 0, zero=1, ovf=0.
- Set-less:
  - a=0xFFFFFFFF (-1), b=1, class 01 -> ALU driven class 10 / opcode 11; data 1.
  - a=0x80000000, b=1 -> data 1 (overflow-corrected).
  - a=3, b=-2 -> data 0, zero=1.
- Back-pressure: hold res_ready=0 and send 3 back-to-back commands -> two are accepted, in_ready stays 0 and res_* hold the first entry. Raise res_ready -> results pop in order, then the third command is accepted.
- Stats with ALU_SEQ_STATS_EN: 4 ops, 1 overflowing -> stat_ops=4, stat_ovf=1. Without the macro -> both read 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command and result handshake bundle between the issue logic and alu_op_sequencer.
// The issuer uses the master modport; the sequencer uses the slave modport.
interface alu_op_sequencer_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [1:0]       in_opcode;
    logic [1:0]       in_fn_class;
    logic [TAG_W-1:0] in_tag;

    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_data;
    logic             res_zero;
    logic             res_ovf;
    logic             res_carry;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_fn_class, in_tag, res_ready,
        input  in_ready, res_valid, res_data, res_zero, res_ovf, res_carry, res_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_fn_class, in_tag, res_ready,
        output in_ready, res_valid, res_data, res_zero, res_ovf, res_carry, res_tag
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues commands to an external combinational ALU, derives flags / set-less-than, and
// returns tagged results through a 2-entry FIFO. Define ALU_SEQ_STATS_EN for op/overflow counters.
module alu_op_sequencer #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus,
    output logic [N-1:0]         alu_a_o,
    output logic [N-1:0]         alu_b_o,
    output logic [1:0]           alu_opcode_o,
    output logic [1:0]           alu_fn_class_o,
    input  logic [N-1:0]         alu_out_i,
    input  logic                 alu_c_out_i,
    output logic [31:0]          stat_ops_o,
    output logic [31:0]          stat_ovf_o
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    typedef struct packed {
        logic [N-1:0]     data;
        logic             zero;
        logic             ovf;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t           state_q;
    logic [1:0]       cmdClass_q;
    logic [TAG_W-1:0] cmdTag_q;
    logic [N-1:0]     aluA_q;
    logic [N-1:0]     aluB_q;
    logic [1:0]       aluOpcode_q;
    logic [1:0]       aluFnClass_q;

    entry_t           fifo_q [2];
    logic             rdPtr_q;
    logic             wrPtr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic [N-1:0]     bEff;
    logic             sltV;
    entry_t           pushEntry;
    entry_t           head;

    // rst_n gates ready so the issuer sees no space while the block is held in reset.
    assign bus.in_ready = rst_n && (state_q == IDLE) && (count_q != 2'd2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = (state_q == ISSUE);
    assign pop          = (count_q != 2'd0) && bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmdClass_q   <= 2'b00;
            cmdTag_q     <= '0;
            aluA_q       <= '0;
            aluB_q       <= '0;
            aluOpcode_q  <= 2'b00;
            aluFnClass_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        aluA_q     <= bus.in_a;
                        aluB_q     <= bus.in_b;
                        cmdClass_q <= bus.in_fn_class;
                        cmdTag_q   <= bus.in_tag;
                        // Set-less-than is evaluated as an ALU subtract.
                        if (bus.in_fn_class == 2'b01) begin
                            aluFnClass_q <= 2'b10;
                            aluOpcode_q  <= 2'b11;
                        end else begin
                            aluFnClass_q <= bus.in_fn_class;
                            aluOpcode_q  <= bus.in_opcode;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a_o        = aluA_q;
    assign alu_b_o        = aluB_q;
    assign alu_opcode_o   = aluOpcode_q;
    assign alu_fn_class_o = aluFnClass_q;

    always_comb begin
        pushEntry = '0;
        bEff      = (aluOpcode_q == 2'b11) ? ({N{1'b0}} - aluB_q) : aluB_q;
        sltV      = (aluA_q[N-1] != aluB_q[N-1]) && (alu_out_i[N-1] != aluA_q[N-1]);
        case (cmdClass_q)
            2'b10: begin
                pushEntry.data  = alu_out_i;
                pushEntry.carry = alu_c_out_i;
                pushEntry.ovf   = (aluA_q[N-1] == bEff[N-1]) && (alu_out_i[N-1] != aluA_q[N-1]);
            end
            2'b01: begin
                pushEntry.data = {{(N-1){1'b0}}, alu_out_i[N-1] ^ sltV};
            end
            default: begin
                pushEntry.data = alu_out_i;
            end
        endcase
        pushEntry.zero = ~|pushEntry.data;
        pushEntry.tag  = cmdTag_q;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wrPtr_q] <= pushEntry;
                wrPtr_q         <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

    assign head          = fifo_q[rdPtr_q];
    assign bus.res_valid = (count_q != 2'd0);
    assign bus.res_data  = head.data;
    assign bus.res_zero  = head.zero;
    assign bus.res_ovf   = head.ovf;
    assign bus.res_carry = head.carry;
    assign bus.res_tag   = head.tag;

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] statOps_q;
    logic [31:0] statOvf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statOps_q <= 32'd0;
            statOvf_q <= 32'd0;
        end else begin
            if (push) begin
                statOps_q <= statOps_q + 32'd1;
            end
            if (push && pushEntry.ovf) begin
                statOvf_q <= statOvf_q + 32'd1;
            end
        end
    end

    assign stat_ops_o = statOps_q;
    assign stat_ovf_o = statOvf_q;
`else
    assign stat_ops_o = 32'd0;
    assign stat_ovf_o = 32'd0;
`endif

endmodule
